// File: rtl/cls_pkg.sv
// Shared types and default constants for the lockstep-cluster recovery sequencer.
package cls_pkg;

  typedef enum logic [2:0] {
    CLS_BOOT     = 3'd0,
    CLS_GRACE    = 3'd1,
    CLS_RUN      = 3'd2,
    CLS_HALT     = 3'd3,
    CLS_RESET    = 3'd4,
    CLS_FAILSAFE = 3'd5
  } cls_rec_state_e;

  localparam int CLS_RST_CYCLES   = 8;
  localparam int CLS_GRACE_CYCLES = 16;
  localparam int CLS_HALT_TIMEOUT = 64;
  localparam int CLS_MAX_RETRY    = 3;
  localparam int CLS_DECAY_CYCLES = 1024;

  function automatic int cls_max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cls_cycle_timer.sv
// Loadable down-counter shared by the timed states; holds at zero.
module cls_cycle_timer #(
  parameter int W    = 7,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] value_q, value_d;

  // next count: load wins, otherwise count down until zero
  always_comb begin
    value_d = value_q;
    if (load)               value_d = load_val;
    else if (value_q != '0) value_d = value_q - W'(1);
  end

  // count register, reset value matches the boot duration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= W'(INIT);
    else      value_q <= value_d;
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/cls_recovery_ctrl.sv
// Fault-recovery sequencer for the triple-core lockstep cluster.
// Optional fault timestamp log enabled by defining CLS_FAULT_LOG_EN.
module cls_recovery_ctrl
  import cls_pkg::*;
#(
  parameter int RST_CYCLES   = CLS_RST_CYCLES,
  parameter int GRACE_CYCLES = CLS_GRACE_CYCLES,
  parameter int HALT_TIMEOUT = CLS_HALT_TIMEOUT,
  parameter int MAX_RETRY    = CLS_MAX_RETRY,
  parameter int DECAY_CYCLES = CLS_DECAY_CYCLES,
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fault,
  input  logic          core_busy_ms,
  input  logic          core_busy_sl1,
  input  logic          core_busy_sl2,
  input  logic          irq_ack,
  output logic          cmp_en,
  output logic          core_halt,
  output logic          core_rst_n,
  output logic          irq,
  output logic          fail_safe,
  output logic [RW-1:0] retry_cnt,
`ifdef CLS_FAULT_LOG_EN
  output logic [31:0]   fault_ts,
`endif
  output logic [2:0]    state_o
);

  localparam int TW = $clog2(cls_max3(RST_CYCLES, GRACE_CYCLES, HALT_TIMEOUT) + 1);
  localparam int DW = $clog2(DECAY_CYCLES + 1);
  localparam logic [TW-1:0] T_RST   = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] T_GRACE = TW'(GRACE_CYCLES - 1);
  localparam logic [TW-1:0] T_HALT  = TW'(HALT_TIMEOUT - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(DECAY_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRY);

  cls_rec_state_e state_q, state_d;
  logic [RW-1:0]  retry_q, retry_d, retry_inc;
  logic [DW-1:0]  clean_q, clean_d;
  logic           irq_q, irq_d;
  logic           tmr_load, tmr_zero;
  logic [TW-1:0]  tmr_val, tmr_value;
  logic           fault_acc;
  logic           any_busy;

  cls_cycle_timer #(.W(TW), .INIT(RST_CYCLES - 1)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  assign any_busy  = core_busy_ms | core_busy_sl1 | core_busy_sl2;
  assign retry_inc = retry_q + RW'(1);

  // next-state, timer loads on state entry, retry/decay and irq set/clear
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    retry_d   = retry_q;
    clean_d   = '0;
    irq_d     = irq_q & ~irq_ack;
    fault_acc = 1'b0;
    case (state_q)
      CLS_BOOT, CLS_RESET: if (tmr_zero) begin
        state_d  = CLS_GRACE;
        tmr_load = 1'b1;
        tmr_val  = T_GRACE;
      end
      CLS_GRACE: if (tmr_zero) state_d = CLS_RUN;
      CLS_RUN: begin
        if (fault) begin
          fault_acc = 1'b1;
          retry_d   = retry_inc;
          irq_d     = 1'b1;
          if (retry_inc == R_MAX) state_d = CLS_FAILSAFE;
          else begin
            state_d  = CLS_HALT;
            tmr_load = 1'b1;
            tmr_val  = T_HALT;
          end
        end else if (clean_q == D_LAST) begin
          if (retry_q != '0) retry_d = retry_q - RW'(1);
        end else begin
          clean_d = clean_q + DW'(1);
        end
      end
      CLS_HALT: if (!any_busy || tmr_zero) begin
        state_d  = CLS_RESET;
        tmr_load = 1'b1;
        tmr_val  = T_RST;
      end
      CLS_FAILSAFE: state_d = CLS_FAILSAFE;
      default: state_d = CLS_BOOT;
    endcase
  end

  // state, retry, decay and irq registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLS_BOOT;
      retry_q <= '0;
      clean_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      clean_q <= clean_d;
      irq_q   <= irq_d;
    end
  end

`ifdef CLS_FAULT_LOG_EN
  logic [31:0] cyc_q, cyc_d, ts_q, ts_d;

  // free-running cycle counter and timestamp capture on accepted faults
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ts_d  = fault_acc ? cyc_q : ts_q;
  end

  // timestamp log registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_d;
      ts_q  <= ts_d;
    end
  end

  assign fault_ts = ts_q;
`endif

  // outputs decoded from registered state
  assign cmp_en     = (state_q == CLS_RUN);
  assign core_halt  = (state_q == CLS_HALT) || (state_q == CLS_RESET) ||
                      (state_q == CLS_FAILSAFE);
  assign core_rst_n = !((state_q == CLS_BOOT) || (state_q == CLS_RESET) ||
                        (state_q == CLS_FAILSAFE));
  assign fail_safe  = (state_q == CLS_FAILSAFE);
  assign irq        = irq_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: doc/cls_recovery_ctrl.md
# cls_recovery_ctrl

Fault-recovery sequencer for the triple-core lockstep cluster. It consumes the lockstep comparator's `fault` flag and the three cores' busy signals, and gates the comparator's effective window. On a mismatch it halts, resets and re-synchronises the master and both slave cores, then re-enables checking. It escalates to a sticky fail-safe state after repeated faults. It sits between the comparator and the cores' reset/halt inputs, alongside the cluster interrupt controller.

## Interface
Parameters:
- `RST_CYCLES`, 8: cycles core reset is held low (boot and recovery); ≥1.
- `GRACE_CYCLES`, 16: cycles after core reset release with checking masked; ≥1.
- `HALT_TIMEOUT`, 64: maximum cycles to wait for cores to go idle; ≥1.
- `MAX_RETRY`, 3: retry count at which the block enters fail-safe; ≥1.
- `DECAY_CYCLES`, 1024: clean RUN cycles per retry-count decrement; ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `fault`, in, 1: comparator mismatch flag.
- `core_busy_ms`, `core_busy_sl1`, `core_busy_sl2`, in, 1 each: core busy.
- `irq_ack`, in, 1: single-cycle pulse that clears `irq`.
- `cmp_en`, out, 1: comparator result is qualified. It is high only in RUN.
- `core_halt`, out, 1: stall request to all three cores.
- `core_rst_n`, out, 1: active-low reset to all three cores.
- `irq`, out, 1: sticky fault interrupt.
- `fail_safe`, out, 1: cluster permanently disabled until `rst`.
- `retry_cnt`, out, $clog2(MAX_RETRY+1): current retry count.
- `state_o`, out, 3: encoded FSM state.
- `fault_ts`, out, 32: cycle timestamp of the last accepted fault. Present only with `CLS_FAULT_LOG_EN`.

## Operation
States and encodings:
- BOOT (0): hold `core_rst_n`=0 for RST_CYCLES, then go to GRACE.
- GRACE (1): cores run with `core_rst_n`=1 and `cmp_en`=0. After GRACE_CYCLES, go to RUN.
- RUN (2): `cmp_en`=1.
  - `fault`=1 → increment `retry_cnt` and set `irq`.
  - If the new count equals MAX_RETRY, go to FAILSAFE; otherwise go to HALT.
- HALT (3): `core_halt`=1. Leave for RESET when all three busy inputs are low, or after HALT_TIMEOUT cycles, whichever comes first.
- RESET (4): `core_halt`=1 and `core_rst_n`=0 for RST_CYCLES, then go to GRACE.
- FAILSAFE (5): `core_halt`=1, `core_rst_n`=0, `fail_safe`=1. The state is absorbing; only `rst` exits it.

Rules:
- `fault` is ignored in every state except RUN. This masks comparator transients during reset and resync.
- Retry decay:
  - In RUN, a clean-cycle counter increments on each cycle with `fault`=0.
  - When it reaches DECAY_CYCLES, `retry_cnt` decrements (saturating at 0) and the counter clears.
  - Leaving RUN clears the counter.
- `irq_ack` and a new fault in the same cycle: set wins, so `irq` stays 1.
- A single down-counter is shared by BOOT, HALT, RESET and GRACE. It is loaded on state entry with the duration minus 1, and the transition fires when it reaches 0.

## Timing
- Reset values: state BOOT; `core_rst_n`=0, `core_halt`=0, `cmp_en`=0, `irq`=0, `fail_safe`=0, `retry_cnt`=0, `fault_ts`=0.
- All outputs are registered. `cmp_en`, `core_halt`, `core_rst_n` and `fail_safe` are decoded from the state register.
- Fault sampled at edge N:
  - At edge N the state becomes HALT or FAILSAFE. In the cycle following edge N, `cmp_en`=0, `core_halt`=1, `irq`=1 and `retry_cnt` is updated.
- Recovery duration: HALT is 1 to HALT_TIMEOUT cycles. With busy inputs already low, HALT lasts exactly 1 cycle, RESET lasts RST_CYCLES and GRACE lasts GRACE_CYCLES.
- Reset asserted mid-operation: asynchronous return to BOOT with all reset values. There is no partial state retention.

## Configuration
- `CLS_FAULT_LOG_EN` defined:
  - A free-running 32-bit cycle counter is instantiated; it starts at 0 after reset and wraps.
  - `fault_ts` captures the counter value at each accepted fault. It is not updated on ignored faults.
- Not defined: the counter and the `fault_ts` port are absent. All other behaviour is identical.

## Structure
- Shared package `cls_pkg` holds:
  - the `cls_rec_state_e` enum (3-bit, encodings above);
  - the default parameter constants, reused by the comparator wrapper and the testbench.
- One sub-module, `cls_cycle_timer`: a loadable down-counter with a `load`, `value` and `zero` interface, sized to the maximum of the duration parameters.
- The FSM, retry/decay logic and optional log live in the top module.

## Test plan
All scenarios use default parameters.
- Boot: release `rst` → `core_rst_n` is 0 for 8 cycles, then 1; `cmp_en` rises 16 cycles later; `state_o`=2.
- Single fault in RUN with busy low → next cycle `irq`=1, `retry_cnt`=1, `core_halt`=1; HALT lasts 1 cycle, RESET 8 cycles, GRACE 16 cycles, then RUN.
- `core_busy_sl2` stuck at 1 → HALT lasts exactly 64 cycles, then RESET.
- Three faults, each injected immediately after RUN re-entry → third fault gives `retry_cnt`=3, `fail_safe`=1, `core_rst_n`=0. Further `fault` pulses and `irq_ack` leave `fail_safe` set; only `rst` clears it.
- One fault, then 1024 clean RUN cycles → `retry_cnt` goes 1→0. A `fault` pulse during GRACE is ignored (`retry_cnt` unchanged).
- `irq_ack` coincident with a fault → `irq` stays 1. With `CLS_FAULT_LOG_EN`, `fault_ts` equals the cycle counter value at that fault edge.
